// File: rtl/pc_redirect_ctrl.sv
// Next-PC sequencer: arbitrates exception/eret/E-fix/D-branch redirects ahead of the
// fetch PC register, enforcing MIPS delay-slot ordering and holding redirects across IF stalls.
module pc_redirect_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'hBFC0_0000,
    parameter bit          DS_ENABLE = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] f_pcplus4,
    input  logic        fetch_ready,
    input  logic        ds_in_f,
    input  logic        exc_valid,
    input  logic [31:0] exc_addr,
    input  logic        eret,
    input  logic [31:0] cp0_epc,
    input  logic        bfrome,
    input  logic [31:0] e_fix_pc,
    input  logic        d_redirect,
    input  logic [31:0] d_target,
    output logic [31:0] next_pc,
    output logic        pc_we,
    output logic        flush_f,
    output logic        stall_d,
    output logic [2:0]  redirect_src
);

    typedef enum logic [1:0] {StIdle, StWaitDs, StHold} state_e;

    localparam logic [2:0] SrcSeq  = 3'b000;
    localparam logic [2:0] SrcD    = 3'b001;
    localparam logic [2:0] SrcE    = 3'b010;
    localparam logic [2:0] SrcEret = 3'b011;
    localparam logic [2:0] SrcExc  = 3'b100;

    state_e      state_q, state_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [2:0]  pend_src_q, pend_src_d;

    logic        hi_valid;
    logic [31:0] hi_pc;
    logic [2:0]  hi_src;

    // Commit-point and E-stage sources, already in priority order.
    always_comb begin
        hi_valid = exc_valid | eret | bfrome;
        hi_pc    = e_fix_pc;
        hi_src   = SrcE;
        if (exc_valid) begin
            hi_pc  = exc_addr;
            hi_src = SrcExc;
        end else if (eret) begin
            hi_pc  = cp0_epc;
            hi_src = SrcEret;
        end
    end

    always_comb begin
        state_d      = state_q;
        pend_pc_d    = pend_pc_q;
        pend_src_d   = pend_src_q;
        next_pc      = f_pcplus4;
        pc_we        = 1'b0;
        flush_f      = 1'b0;
        stall_d      = 1'b0;
        redirect_src = SrcSeq;

        if (hi_valid) begin
            // Overrides and discards any pending D redirect.
            next_pc      = hi_pc;
            redirect_src = hi_src;
            flush_f      = 1'b1;
            pc_we        = fetch_ready;
            if (fetch_ready) begin
                state_d = StIdle;
            end else begin
                pend_pc_d  = hi_pc;
                pend_src_d = hi_src;
                state_d    = StHold;
            end
        end else begin
            case (state_q)
                StIdle: begin
                    if (d_redirect) begin
                        next_pc      = d_target;
                        redirect_src = SrcD;
                        if (!DS_ENABLE || ds_in_f) begin
                            pc_we   = fetch_ready;
                            flush_f = !DS_ENABLE;
                            if (!fetch_ready) begin
                                pend_pc_d  = d_target;
                                pend_src_d = SrcD;
                                state_d    = StHold;
                            end
                        end else begin
                            // Delay slot not yet in F: park the target until it arrives.
                            pend_pc_d  = d_target;
                            pend_src_d = SrcD;
                            state_d    = StWaitDs;
                        end
                    end else begin
                        pc_we = fetch_ready;
                    end
                end
                StWaitDs: begin
                    stall_d      = 1'b1;
                    next_pc      = pend_pc_q;
                    redirect_src = SrcD;
                    if (ds_in_f) begin
                        pc_we   = fetch_ready;
                        state_d = fetch_ready ? StIdle : StHold;
                    end
                end
                StHold: begin
                    stall_d      = 1'b1;
                    next_pc      = pend_pc_q;
                    redirect_src = pend_src_q;
                    pc_we        = fetch_ready;
                    flush_f      = (pend_src_q != SrcD) || !DS_ENABLE;
                    if (fetch_ready) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        if (!resetn) begin
            next_pc      = RESET_PC;
            pc_we        = 1'b0;
            flush_f      = 1'b0;
            stall_d      = 1'b0;
            redirect_src = SrcSeq;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            pend_pc_q  <= RESET_PC;
            pend_src_q <= SrcSeq;
        end else begin
            state_q    <= state_d;
            pend_pc_q  <= pend_pc_d;
            pend_src_q <= pend_src_d;
        end
    end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl: one task per scenario with inline expected values.
module tb_pc_redirect_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] f_pcplus4;
    logic        fetch_ready;
    logic        ds_in_f;
    logic        exc_valid;
    logic [31:0] exc_addr;
    logic        eret;
    logic [31:0] cp0_epc;
    logic        bfrome;
    logic [31:0] e_fix_pc;
    logic        d_redirect;
    logic [31:0] d_target;
    logic [31:0] next_pc;
    logic        pc_we;
    logic        flush_f;
    logic        stall_d;
    logic [2:0]  redirect_src;

    int checks = 0;
    int errors = 0;

    pc_redirect_ctrl dut (
        .clk          (clk),
        .resetn       (resetn),
        .f_pcplus4    (f_pcplus4),
        .fetch_ready  (fetch_ready),
        .ds_in_f      (ds_in_f),
        .exc_valid    (exc_valid),
        .exc_addr     (exc_addr),
        .eret         (eret),
        .cp0_epc      (cp0_epc),
        .bfrome       (bfrome),
        .e_fix_pc     (e_fix_pc),
        .d_redirect   (d_redirect),
        .d_target     (d_target),
        .next_pc      (next_pc),
        .pc_we        (pc_we),
        .flush_f      (flush_f),
        .stall_d      (stall_d),
        .redirect_src (redirect_src)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ds_in_f    = 1'b0;
        exc_valid  = 1'b0;
        eret       = 1'b0;
        bfrome     = 1'b0;
        d_redirect = 1'b0;
    endtask

    task automatic test_reset();
        resetn      = 1'b0;
        clear_inputs();
        f_pcplus4   = 32'h1234_5678;
        fetch_ready = 1'b1;
        exc_valid   = 1'b1;
        exc_addr    = 32'hBFC0_0380;
        d_redirect  = 1'b1;
        d_target    = 32'h8000_0040;
        #3;
        checks++; if (next_pc !== 32'hBFC0_0000) begin errors++;
            $display("FAIL reset_next_pc got %h want %h", next_pc, 32'hBFC0_0000); end
        checks++; if (pc_we !== 1'b0) begin errors++;
            $display("FAIL reset_pc_we got %b want 0", pc_we); end
        checks++; if (flush_f !== 1'b0 || stall_d !== 1'b0) begin errors++;
            $display("FAIL reset_flush_stall got %b%b want 00", flush_f, stall_d); end
        checks++; if (redirect_src !== 3'b000) begin errors++;
            $display("FAIL reset_src got %b want 000", redirect_src); end
        clear_inputs();
        step();
        step();
        #3 resetn = 1'b1;
    endtask

    task automatic test_seq();
        step();
        fetch_ready = 1'b1;
        f_pcplus4   = 32'hBFC0_0004;
        #1;
        checks++; if (pc_we !== 1'b1 || next_pc !== 32'hBFC0_0004) begin errors++;
            $display("FAIL seq got we=%b pc=%h want we=1 pc=bfc00004", pc_we, next_pc); end
        checks++; if (redirect_src !== 3'b000 || flush_f !== 1'b0) begin errors++;
            $display("FAIL seq_src got src=%b fl=%b want 000/0", redirect_src, flush_f); end
        fetch_ready = 1'b0;
        #1;
        checks++; if (pc_we !== 1'b0) begin errors++;
            $display("FAIL seq_not_ready got we=%b want 0", pc_we); end
    endtask

    task automatic test_ds_branch();
        step();
        fetch_ready = 1'b1;
        f_pcplus4   = 32'hBFC0_0008;
        d_redirect  = 1'b1;
        d_target    = 32'h8000_1000;
        ds_in_f     = 1'b0;
        #1;
        checks++; if (pc_we !== 1'b0 || stall_d !== 1'b0) begin errors++;
            $display("FAIL ds_latch got we=%b st=%b want 0/0", pc_we, stall_d); end
        step();
        #1;
        checks++; if (stall_d !== 1'b1 || pc_we !== 1'b0 || flush_f !== 1'b0) begin errors++;
            $display("FAIL ds_wait got st=%b we=%b fl=%b want 1/0/0", stall_d, pc_we, flush_f); end
        step();
        d_redirect = 1'b0;
        ds_in_f    = 1'b1;
        #1;
        checks++; if (pc_we !== 1'b1 || next_pc !== 32'h8000_1000) begin errors++;
            $display("FAIL ds_take got we=%b pc=%h want 1/80001000", pc_we, next_pc); end
        checks++; if (flush_f !== 1'b0 || redirect_src !== 3'b001) begin errors++;
            $display("FAIL ds_take_src got fl=%b src=%b want 0/001", flush_f, redirect_src); end
        step();
        ds_in_f   = 1'b0;
        f_pcplus4 = 32'h8000_1004;
        #1;
        checks++; if (stall_d !== 1'b0 || next_pc !== 32'h8000_1004) begin errors++;
            $display("FAIL ds_idle got st=%b pc=%h want 0/80001004", stall_d, next_pc); end
    endtask

    task automatic test_ds_immediate();
        step();
        d_redirect  = 1'b1;
        d_target    = 32'h8000_3000;
        ds_in_f     = 1'b1;
        fetch_ready = 1'b0;
        #1;
        checks++; if (pc_we !== 1'b0 || flush_f !== 1'b0 || redirect_src !== 3'b001) begin
            errors++;
            $display("FAIL dimm got we=%b fl=%b src=%b want 0/0/001", pc_we, flush_f,
                     redirect_src); end
        step();
        d_redirect = 1'b0;
        ds_in_f    = 1'b0;
        #1;
        checks++; if (stall_d !== 1'b1 || flush_f !== 1'b0 || next_pc !== 32'h8000_3000) begin
            errors++;
            $display("FAIL dimm_hold got st=%b fl=%b pc=%h want 1/0/80003000", stall_d, flush_f,
                     next_pc); end
        fetch_ready = 1'b1;
        #1;
        checks++; if (pc_we !== 1'b1) begin errors++;
            $display("FAIL dimm_release got we=%b want 1", pc_we); end
    endtask

    task automatic test_hold();
        step();
        f_pcplus4   = 32'h8000_3004;
        bfrome      = 1'b1;
        e_fix_pc    = 32'h8000_2000;
        fetch_ready = 1'b0;
        #1;
        checks++; if (flush_f !== 1'b1 || pc_we !== 1'b0 || redirect_src !== 3'b010) begin
            errors++;
            $display("FAIL efix got fl=%b we=%b src=%b want 1/0/010", flush_f, pc_we,
                     redirect_src); end
        step();
        bfrome     = 1'b0;
        d_redirect = 1'b1;
        d_target   = 32'hDEAD_0000;
        #1;
        checks++; if (stall_d !== 1'b1 || flush_f !== 1'b1 || pc_we !== 1'b0 ||
                      next_pc !== 32'h8000_2000) begin errors++;
            $display("FAIL hold2 got st=%b fl=%b we=%b pc=%h want 1/1/0/80002000", stall_d,
                     flush_f, pc_we, next_pc); end
        step();
        #1;
        checks++; if (pc_we !== 1'b0 || next_pc !== 32'h8000_2000) begin errors++;
            $display("FAIL hold3 got we=%b pc=%h want 0/80002000", pc_we, next_pc); end
        step();
        fetch_ready = 1'b1;
        d_redirect  = 1'b0;
        #1;
        checks++; if (pc_we !== 1'b1 || next_pc !== 32'h8000_2000 || redirect_src !== 3'b010)
        begin errors++;
            $display("FAIL hold4 got we=%b pc=%h src=%b want 1/80002000/010", pc_we, next_pc,
                     redirect_src); end
        step();
        #1;
        checks++; if (stall_d !== 1'b0 || redirect_src !== 3'b000) begin errors++;
            $display("FAIL hold_exit got st=%b src=%b want 0/000", stall_d, redirect_src); end
    endtask

    task automatic test_exc_over_pending();
        step();
        fetch_ready = 1'b1;
        d_redirect  = 1'b1;
        d_target    = 32'h8000_4000;
        ds_in_f     = 1'b0;
        step();
        d_redirect = 1'b0;
        exc_valid  = 1'b1;
        exc_addr   = 32'hBFC0_0380;
        #1;
        checks++; if (next_pc !== 32'hBFC0_0380 || redirect_src !== 3'b100) begin errors++;
            $display("FAIL exc_pend got pc=%h src=%b want bfc00380/100", next_pc,
                     redirect_src); end
        checks++; if (flush_f !== 1'b1 || pc_we !== 1'b1) begin errors++;
            $display("FAIL exc_pend_ctl got fl=%b we=%b want 1/1", flush_f, pc_we); end
        step();
        exc_valid = 1'b0;
        ds_in_f   = 1'b1;
        f_pcplus4 = 32'hBFC0_0384;
        #1;
        checks++; if (redirect_src !== 3'b000 || next_pc !== 32'hBFC0_0384 || stall_d !== 1'b0)
        begin errors++;
            $display("FAIL exc_drop got src=%b pc=%h st=%b want 000/bfc00384/0", redirect_src,
                     next_pc, stall_d); end
        ds_in_f = 1'b0;
    endtask

    task automatic test_exc_eret();
        step();
        fetch_ready = 1'b1;
        exc_valid   = 1'b1;
        exc_addr    = 32'hBFC0_0380;
        eret        = 1'b1;
        cp0_epc     = 32'h8000_5000;
        bfrome      = 1'b1;
        #1;
        checks++; if (next_pc !== 32'hBFC0_0380 || redirect_src !== 3'b100) begin errors++;
            $display("FAIL exc_vs_eret got pc=%h src=%b want bfc00380/100", next_pc,
                     redirect_src); end
        step();
        exc_valid = 1'b0;
        #1;
        checks++; if (next_pc !== 32'h8000_5000 || redirect_src !== 3'b011) begin errors++;
            $display("FAIL eret_vs_efix got pc=%h src=%b want 80005000/011", next_pc,
                     redirect_src); end
        step();
        eret   = 1'b0;
        bfrome = 1'b0;
    endtask

    task automatic test_reset_mid_hold();
        step();
        eret        = 1'b1;
        cp0_epc     = 32'h8000_6000;
        fetch_ready = 1'b0;
        step();
        eret        = 1'b0;
        fetch_ready = 1'b1;
        f_pcplus4   = 32'h8000_6004;
        #1;
        checks++; if (stall_d !== 1'b1 || next_pc !== 32'h8000_6000 || pc_we !== 1'b1) begin
            errors++;
            $display("FAIL rhold got st=%b pc=%h we=%b want 1/80006000/1", stall_d, next_pc,
                     pc_we); end
        resetn = 1'b0;
        #1;
        checks++; if (next_pc !== 32'hBFC0_0000 || pc_we !== 1'b0 || flush_f !== 1'b0 ||
                      stall_d !== 1'b0 || redirect_src !== 3'b000) begin errors++;
            $display("FAIL rmid got pc=%h we=%b fl=%b st=%b src=%b want bfc00000/0/0/0/000",
                     next_pc, pc_we, flush_f, stall_d, redirect_src); end
        step();
        #3 resetn = 1'b1;
        step();
        #1;
        checks++; if (redirect_src !== 3'b000 || stall_d !== 1'b0 || pc_we !== 1'b1 ||
                      next_pc !== 32'h8000_6004) begin errors++;
            $display("FAIL rpost got src=%b st=%b we=%b pc=%h want 000/0/1/80006004",
                     redirect_src, stall_d, pc_we, next_pc); end
    endtask

    initial begin
        exc_addr = '0;
        cp0_epc  = '0;
        e_fix_pc = '0;
        test_reset();
        test_seq();
        test_ds_branch();
        test_ds_immediate();
        test_hold();
        test_exc_over_pending();
        test_exc_eret();
        test_reset_mid_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
